// File: rtl/snake_score_counter.sv
// Packed-BCD score keeper for the snake game: edge-detected food events, saturating
// BCD score, persistent high score and a registered display mux.
module snake_score_counter #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eat,
    input  logic        game_over,
    input  logic        new_game,
    input  logic        show_high,
    output logic [15:0] score,
    output logic [15:0] high,
    output logic [15:0] disp,
    output logic        playing,
    output logic        new_record,
    output logic        saturated
);

    typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

    localparam logic [3:0] STEP_BCD = 4'(STEP);

    state_t      state_q, state_d;
    logic        eat_q, eat_d;
    logic        go_q, go_d;
    logic [15:0] score_q, score_d;
    logic [15:0] high_q, high_d;
    logic [15:0] disp_q, disp_d;
    logic        new_record_q, new_record_d;
    logic        saturated_q, saturated_d;

    logic        eat_ev, go_ev;
    logic [16:0] add_res;
    logic [15:0] inc_score;
    logic        inc_sat;

    // Ripple BCD add of a single digit into the ones place; bit 16 is the carry out.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
        logic [4:0]  s;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[i*4 +: 4]} + ((i == 0) ? {1'b0, b} : 5'd0) + {4'b0000, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4 +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    assign eat_ev  = eat & ~eat_q;
    assign go_ev   = game_over & ~go_q;
    assign add_res = bcd_add(score_q, STEP_BCD);

    always_comb begin
        inc_score = score_q;
        inc_sat   = saturated_q;
        if (eat_ev) begin
            if (add_res[16]) begin
                inc_score = 16'h9999;
                inc_sat   = 1'b1;
            end else begin
                inc_score = add_res[15:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        eat_d        = eat;
        go_d         = game_over;
        score_d      = score_q;
        high_d       = high_q;
        new_record_d = new_record_q;
        saturated_d  = saturated_q;
        disp_d       = show_high ? high_q : score_q;

        if (new_game) begin
            state_d      = PLAY;
            score_d      = '0;
            saturated_d  = 1'b0;
            new_record_d = 1'b0;
        end else if (state_q == PLAY) begin
            score_d     = inc_score;
            saturated_d = inc_sat;
            // Commit sees the same-cycle increment; BCD compares like binary.
            if (go_ev) begin
                state_d = OVER;
                if (inc_score > high_q) begin
                    high_d       = inc_score;
                    new_record_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PLAY;
            eat_q        <= 1'b1;
            go_q         <= 1'b1;
            score_q      <= '0;
            high_q       <= '0;
            disp_q       <= '0;
            new_record_q <= 1'b0;
            saturated_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            eat_q        <= eat_d;
            go_q         <= go_d;
            score_q      <= score_d;
            high_q       <= high_d;
            disp_q       <= disp_d;
            new_record_q <= new_record_d;
            saturated_q  <= saturated_d;
        end
    end

    assign score      = score_q;
    assign high       = high_q;
    assign disp       = disp_q;
    assign playing    = (state_q == PLAY);
    assign new_record = new_record_q;
    assign saturated  = saturated_q;

endmodule
